// File: rtl/bip_pkg.sv
// Shared opcode, select and FSM encodings for the branch/sequencing controller.
package bip_pkg;

   localparam int NB_OPC_DEF = 5;

   localparam logic [NB_OPC_DEF-1:0] OP_HLT  = 5'b00000;
   localparam logic [NB_OPC_DEF-1:0] OP_STO  = 5'b00001;
   localparam logic [NB_OPC_DEF-1:0] OP_LD   = 5'b00010;
   localparam logic [NB_OPC_DEF-1:0] OP_LDI  = 5'b00011;
   localparam logic [NB_OPC_DEF-1:0] OP_ADD  = 5'b00100;
   localparam logic [NB_OPC_DEF-1:0] OP_ADDI = 5'b00101;
   localparam logic [NB_OPC_DEF-1:0] OP_SUB  = 5'b00110;
   localparam logic [NB_OPC_DEF-1:0] OP_SUBI = 5'b00111;
   localparam logic [NB_OPC_DEF-1:0] OP_BEQ  = 5'b01000;
   localparam logic [NB_OPC_DEF-1:0] OP_BNE  = 5'b01001;
   localparam logic [NB_OPC_DEF-1:0] OP_JMP  = 5'b01010;

   typedef enum logic [1:0] {
      SEL_A_RAM = 2'b00,
      SEL_A_IMM = 2'b01,
      SEL_A_ALU = 2'b10
   } sel_a_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_FLUSH = 2'b01,
      ST_HALT  = 2'b10
   } state_t;

endpackage

// File: rtl/op_decoder_v2.sv
// Combinational opcode decode: datapath selects, gated strobes and branch/halt flags.
module op_decoder_v2
   import bip_pkg::*;
#(
   parameter int NB_OPCODE = 5
) (
   input  logic [NB_OPCODE-1:0] opcode,
   input  logic                 valid,
   input  logic                 enable,
   output logic [1:0]           sel_a,
   output logic                 sel_b,
   output logic                 operacion,
   output logic                 write_acc,
   output logic                 write_ram,
   output logic                 read_ram,
   output logic                 is_jmp,
   output logic                 is_beq,
   output logic                 is_bne,
   output logic                 is_hlt
);

   logic wa, wr, rr, fire;

   assign fire = valid & enable;

   always_comb begin
      sel_a     = SEL_A_RAM;
      sel_b     = 1'b0;
      operacion = 1'b0;
      wa        = 1'b0;
      wr        = 1'b0;
      rr        = 1'b0;
      is_jmp    = 1'b0;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      is_hlt    = 1'b0;
      case (opcode)
         NB_OPCODE'(OP_HLT):  is_hlt = 1'b1;
         NB_OPCODE'(OP_STO):  wr = 1'b1;
         NB_OPCODE'(OP_LD): begin
            rr = 1'b1;
            wa = 1'b1;
         end
         NB_OPCODE'(OP_LDI): begin
            sel_a = SEL_A_IMM;
            wa    = 1'b1;
         end
         NB_OPCODE'(OP_ADD), NB_OPCODE'(OP_SUB): begin
            rr        = 1'b1;
            sel_a     = SEL_A_ALU;
            operacion = (opcode == NB_OPCODE'(OP_SUB));
            wa        = 1'b1;
         end
         NB_OPCODE'(OP_ADDI), NB_OPCODE'(OP_SUBI): begin
            sel_a     = SEL_A_ALU;
            sel_b     = 1'b1;
            operacion = (opcode == NB_OPCODE'(OP_SUBI));
            wa        = 1'b1;
         end
         NB_OPCODE'(OP_BEQ):  is_beq = 1'b1;
         NB_OPCODE'(OP_BNE):  is_bne = 1'b1;
         NB_OPCODE'(OP_JMP):  is_jmp = 1'b1;
         default: ;
      endcase
   end

   // strobes only fire for a valid instruction while the core is executing
   assign write_acc = wa & fire;
   assign write_ram = wr & fire;
   assign read_ram  = rr & fire;

endmodule

// File: rtl/branch_control.sv
// Program counter, run/flush/halt sequencing and retired-instruction counter.
//   state    | meaning
//   ST_RUN   | executing; valid instructions retire and advance the PC
//   ST_FLUSH | one dead cycle after a taken branch; nothing retires
//   ST_HALT  | HLT retired; everything frozen until reset
module branch_control
   import bip_pkg::*;
#(
   parameter int NB_INSTR  = 16,
   parameter int NB_OPCODE = 5,
   parameter int NB_ADDR   = 11,
   parameter int NB_CNT    = 32
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_valid,
   input  logic [NB_INSTR-1:0]           i_instruction,
   input  logic                          i_acc_zero,
   output logic [NB_INSTR-NB_OPCODE-1:0] o_operand,
   output logic [1:0]                    o_sel_a,
   output logic                          o_sel_b,
   output logic                          o_write_acc,
   output logic                          o_operacion,
   output logic                          o_write_ram,
   output logic                          o_read_ram,
   output logic [NB_ADDR-1:0]            o_addr,
   output logic                          o_halt,
   output logic [NB_CNT-1:0]             o_instr_count
);

   localparam int NB_OPND = NB_INSTR - NB_OPCODE;

   state_t               state, state_next;
   logic [NB_ADDR-1:0]   pc, pc_next;
   logic [NB_CNT-1:0]    cnt, cnt_next, cnt_inc;
   logic [NB_OPCODE-1:0] opcode;
   logic                 run_en, taken;
   logic                 is_jmp, is_beq, is_bne, is_hlt;

   assign opcode    = i_instruction[NB_INSTR-1 -: NB_OPCODE];
   assign o_operand = i_instruction[NB_OPND-1:0];
   assign run_en    = (state == ST_RUN) && !i_reset;

   op_decoder_v2 #(
      .NB_OPCODE (NB_OPCODE)
   ) u_dec (
      .opcode    (opcode),
      .valid     (i_valid),
      .enable    (run_en),
      .sel_a     (o_sel_a),
      .sel_b     (o_sel_b),
      .operacion (o_operacion),
      .write_acc (o_write_acc),
      .write_ram (o_write_ram),
      .read_ram  (o_read_ram),
      .is_jmp    (is_jmp),
      .is_beq    (is_beq),
      .is_bne    (is_bne),
      .is_hlt    (is_hlt)
   );

   assign taken   = is_jmp | (is_beq & i_acc_zero) | (is_bne & ~i_acc_zero);
   assign cnt_inc = (cnt == {NB_CNT{1'b1}}) ? cnt : cnt + NB_CNT'(1);

   always_comb begin
      state_next = state;
      pc_next    = pc;
      cnt_next   = cnt;
      case (state)
         ST_RUN: begin
            if (i_valid) begin
               cnt_next = cnt_inc;
               if (is_hlt) begin
                  state_next = ST_HALT;
               end else if (taken) begin
                  pc_next    = o_operand[NB_ADDR-1:0];
                  state_next = ST_FLUSH;
               end else begin
                  pc_next = pc + NB_ADDR'(1);
               end
            end
         end
         ST_FLUSH: state_next = ST_RUN;
         ST_HALT:  state_next = ST_HALT;
         default:  state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_RUN;
         pc    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         cnt   <= cnt_next;
      end
   end

   assign o_addr        = pc;
   assign o_halt        = (state == ST_HALT);
   assign o_instr_count = cnt;

endmodule

// File: doc/branch_control.md
BRANCH_CONTROL -- requirements
Module: branch_control

Interface
REQ-001 Parameter NB_INSTR, default 16: instruction width.
REQ-002 Parameter NB_OPCODE, default 5: opcode field width, MSBs of instruction.
REQ-003 Parameter NB_ADDR, default 11: program-counter / data-address width; SHALL be <= NB_INSTR-NB_OPCODE.
REQ-004 Parameter NB_CNT, default 32: retired-instruction counter width.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 i_clk  in  1  clock; all state updates on rising edge.
REQ-007 i_reset  in  1  synchronous active-high reset.
REQ-008 i_valid  in  1  instruction on i_instruction is valid this cycle.
REQ-009 i_instruction  in  NB_INSTR  opcode[MSBs] + operand[rest].
REQ-010 i_acc_zero  in  1  accumulator == 0 flag from datapath.
REQ-011 o_operand  out  NB_INSTR-NB_OPCODE  instruction operand field, combinational pass-through.
REQ-012 o_sel_a  out  2  acc source: 00 RAM data, 01 immediate, 10 ALU result.
REQ-013 o_sel_b  out  1  ALU B source: 0 RAM data, 1 immediate.
REQ-014 o_write_acc / o_operacion / o_write_ram / o_read_ram  out  1 each  acc write, ALU op (0 add, 1 sub), RAM write, RAM read.
REQ-015 o_addr  out  NB_ADDR  program counter.
REQ-016 o_halt  out  1  core halted.
REQ-017 o_instr_count  out  NB_CNT  instructions retired since reset.

Function
REQ-018 Opcodes: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111, BEQ 01000, BNE 01001, JMP 01010; all others NOP.
REQ-019 Decode: STO wr_ram; LD rd_ram,sel_a=00,wr_acc; LDI sel_a=01,wr_acc; ADD rd_ram,sel_a=10,sel_b=0,op=0,wr_acc; ADDI sel_a=10,sel_b=1,op=0,wr_acc; SUB/SUBI as ADD/ADDI with op=1; others all strobes 0, sel/op 0.
REQ-020 Strobes (wr_acc, wr_ram, rd_ram) SHALL assert only when state=RUN and i_valid=1; otherwise 0.
REQ-021 FSM states: RUN, FLUSH, HALT; reset enters RUN.
REQ-022 RUN, i_valid=0: PC, state, counter hold.
REQ-023 RUN, i_valid=1, non-branch non-HLT: PC <= PC+1 (wraps 2^NB_ADDR-1 -> 0), counter +1, stay RUN.
REQ-024 Branch taken (JMP; BEQ with i_acc_zero=1; BNE with i_acc_zero=0): PC <= operand[NB_ADDR-1:0], counter +1, -> FLUSH.
REQ-025 Branch not taken: behaves as REQ-023.
REQ-026 FLUSH: exactly one cycle, all strobes 0, PC and counter hold regardless of i_valid, -> RUN.
REQ-027 HLT with i_valid=1: PC holds, counter +1, -> HALT; HALT is absorbing until reset.
REQ-028 HALT: o_halt=1, all strobes 0, PC and counter frozen, i_valid ignored.
REQ-029 o_instr_count SHALL saturate at 2^NB_CNT-1.
REQ-030 Branch target equal to current PC SHALL be legal (self-loop).

Reset
REQ-031 i_reset=1 at any clock edge, in any state: PC=0, state=RUN, counter=0, o_halt=0; reset dominates i_valid.
REQ-032 While i_reset=1 all strobes SHALL be 0.

Structure
REQ-033 Opcode constants, o_sel_a encodings and FSM state encodings SHALL live in shared package bip_pkg.
REQ-034 Combinational decode SHALL be sub-module op_decoder_v2 (opcode, i_valid, state-enable -> strobes, selects, branch/halt flags); PC, FSM and counter in branch_control.

Verification
REQ-035 Reset, then LDI 5, ADDI 3, SUB 10, each i_valid=1 -> o_addr 0,1,2,3; wr_acc each cycle; SUB has rd_ram=1, op=1; count=3.
REQ-036 JMP 0x040 at PC 2 -> next cycle FLUSH (strobes 0, o_addr=0x040), following cycle RUN at 0x040; count +1 only.
REQ-037 BEQ 0x010 with i_acc_zero=0 -> PC+1, no FLUSH; repeat with i_acc_zero=1 -> PC=0x010, FLUSH.
REQ-038 HLT at PC 7 -> o_halt=1, o_addr stays 7 for 10 cycles despite i_valid=1 and STO inputs, wr_ram=0; i_reset -> PC=0, o_halt=0.
REQ-039 PC at 0x7FF (NB_ADDR=11), ADD -> o_addr=0x000; i_valid toggling 1/0 -> PC advances only on valid cycles.
REQ-040 Reset asserted during FLUSH and with i_valid=1 -> next cycle PC=0, RUN, count=0, no strobes.
